rom_port_arbiter: RTL

Two-port arbiter that shares the single byte-wide image/program ROM read channel between the MCU program fetch (port 0) and the LCD segment renderer (port 1). It sits between both requesters and the SDRAM/ROM controller. It latches one outstanding request per port and serves the ports round-robin. Each port gets a ready/read handshake: ready drops after a read is accepted and rises again when the data byte is valid.

---
 rtl/rom_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_port_arbiter
//  Description : Shares one byte-wide ROM read channel between the MCU
//                program fetch (port 0) and the LCD segment renderer
//                (port 1). Each port may hold one outstanding read; ports
//                are served round-robin with a ready/read handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
    parameter int            AW      = 25,
    parameter logic [AW-1:0] P1_BASE = '0
) (
    input  logic          clk_sys,
    input  logic          reset_n,

    input  logic [AW-1:0] p0_addr,
    input  logic          p0_rd,
    output logic          p0_ready,
    output logic [7:0]    p0_data,

    input  logic [AW-1:0] p1_addr,
    input  logic          p1_rd,
    output logic          p1_ready,
    output logic [7:0]    p1_data,

    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,

    output logic          grant,
    output logic          busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_pend;
    logic [AW-1:0] r_addr_q0;
    logic [AW-1:0] r_addr_q1;
    logic          r_last;

    logic [1:0]    w_accept;
    logic          w_sel;
    logic          w_start;
    logic          w_done;

    // A port is ready exactly when it has nothing pending; a strobe only
    // counts while ready, so strobes during service are simply dropped.
    assign p0_ready    = ~r_pend[0];
    assign p1_ready    = ~r_pend[1];
    assign w_accept[0] = p0_rd & ~r_pend[0];
    assign w_accept[1] = p1_rd & ~r_pend[1];
    assign busy        = (r_state == ST_WAIT);

    // Next-state and port selection; on a tie the port not served last wins.
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != 2'b00) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_WAIT;
                    if (r_pend == 2'b11) begin
                        w_sel = ~r_last;
                    end else begin
                        w_sel = r_pend[1];
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-port request latch: set on an accepted strobe, cleared by the ack
    // that completes that port's service.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pend    <= 2'b00;
            r_addr_q0 <= '0;
            r_addr_q1 <= '0;
        end else begin
            if (w_done && (grant == 1'b0)) begin
                r_pend[0] <= 1'b0;
            end else if (w_accept[0]) begin
                r_pend[0] <= 1'b1;
                r_addr_q0 <= p0_addr;
            end
            if (w_done && (grant == 1'b1)) begin
                r_pend[1] <= 1'b0;
            end else if (w_accept[1]) begin
                r_pend[1] <= 1'b1;
                r_addr_q1 <= p1_addr;
            end
        end
    end

    // ROM channel: launch the selected request, hold it until acknowledged.
    // Port 1 addresses are relocated by P1_BASE and wrap at AW bits.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= '0;
            mem_req  <= 1'b0;
            grant    <= 1'b0;
            r_last   <= 1'b1;
        end else if (w_start) begin
            mem_addr <= w_sel ? (r_addr_q1 + P1_BASE) : r_addr_q0;
            mem_req  <= 1'b1;
            grant    <= w_sel;
        end else if (w_done) begin
            mem_req  <= 1'b0;
            r_last   <= grant;
        end
    end

    // Return data to the served port; each port keeps its last byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p0_data <= 8'h00;
            p1_data <= 8'h00;
        end else if (w_done) begin
            if (grant) begin
                p1_data <= mem_data;
            end else begin
                p0_data <= mem_data;
            end
        end
    end

endmodule
`default_nettype wire
